// File: rtl/fpmac_pkg.sv
// Shared FP32 constants and class-flag definitions for the FP MAC result path.
`timescale 1ns/100ps
package fpmac_pkg;

  localparam int unsigned FP32_WIDTH      = 32;
  localparam int unsigned FP32_EXP_WIDTH  = 8;
  localparam int unsigned FP32_MANT_WIDTH = 23;

  localparam int unsigned FLAG_WIDTH = 4;
  localparam int unsigned FLAG_NAN   = 3;
  localparam int unsigned FLAG_INF   = 2;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_SUB   = 0;

  // Bit order matches the FLAG_* indices: {nan, inf, zero, sub}.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
  } fp_flags_t;

endpackage

// File: rtl/fpmac_classify.sv
// Combinational IEEE-754 class decode of one result word into {nan, inf, zero, subnormal}.
`timescale 1ns/100ps
module fpmac_classify
  import fpmac_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = FP32_WIDTH,
  parameter int unsigned EXP_WIDTH  = FP32_EXP_WIDTH,
  parameter int unsigned MANT_WIDTH = FP32_MANT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0]  word,
  output logic [FLAG_WIDTH-1:0] flags
);

  logic [EXP_WIDTH-1:0]  exp_f;
  logic [MANT_WIDTH-1:0] mant_f;
  logic                  exp_ones;
  logic                  exp_zero;
  logic                  mant_zero;
  logic                  unused_sign;

  assign exp_f       = word[BIT_WIDTH-2 -: EXP_WIDTH];
  assign mant_f      = word[MANT_WIDTH-1:0];
  assign exp_ones    = &exp_f;
  assign exp_zero    = ~|exp_f;
  assign mant_zero   = ~|mant_f;
  // Sign never affects the class.
  assign unused_sign = word[BIT_WIDTH-1];

  always_comb begin
    flags            = '0;
    flags[FLAG_NAN]  = exp_ones && !mant_zero;
    flags[FLAG_INF]  = exp_ones && mant_zero;
    flags[FLAG_ZERO] = exp_zero && mant_zero;
    flags[FLAG_SUB]  = exp_zero && !mant_zero;
  end

endmodule

// File: rtl/fpmac_result_collector.sv
// FIFO collector for FP MAC results, tagging each word with class flags at push time.
// Optional NaN/Inf statistics counters are built when FPMAC_STATS_EN is defined.
`timescale 1ns/100ps
module fpmac_result_collector
  import fpmac_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = FP32_WIDTH,
  parameter int unsigned EXP_WIDTH  = FP32_EXP_WIDTH,
  parameter int unsigned MANT_WIDTH = FP32_MANT_WIDTH,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [BIT_WIDTH-1:0]   in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [BIT_WIDTH-1:0]   out_data,
  output logic [3:0]             out_flags,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            total_cnt
`ifdef FPMAC_STATS_EN
  ,
  output logic [15:0]            nan_cnt,
  output logic [15:0]            inf_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [BIT_WIDTH-1:0]  mem_data  [DEPTH];
  fp_flags_t             mem_flags [DEPTH];

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic [31:0]           total_q;
  logic [FLAG_WIDTH-1:0] in_flags;
  logic                  push;
  logic                  pop;

  fpmac_classify #(
    .BIT_WIDTH  (BIT_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH)
  ) u_classify (
    .word  (in_data),
    .flags (in_flags)
  );

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;
  assign total_cnt = total_q;

  // Head is gated so outputs read zero when empty and never expose unreset storage.
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_flags = out_valid ? mem_flags[rd_ptr] : '0;

  // Pointer, occupancy and accepted-word counter; clear overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      total_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      total_q <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        total_q <= total_q + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_data[wr_ptr]  <= in_data;
      mem_flags[wr_ptr] <= fp_flags_t'(in_flags);
    end
  end

`ifdef FPMAC_STATS_EN
  // Saturating NaN/Inf counters, sampled on accepted pushes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_cnt <= '0;
      inf_cnt <= '0;
    end else if (clear) begin
      nan_cnt <= '0;
      inf_cnt <= '0;
    end else if (push) begin
      if (in_flags[FLAG_NAN] && (nan_cnt != 16'hFFFF)) nan_cnt <= nan_cnt + 16'd1;
      if (in_flags[FLAG_INF] && (inf_cnt != 16'hFFFF)) inf_cnt <= inf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpmac_result_collector.sv
// Directed self-checking bench for fpmac_result_collector (DEPTH=8, FP32).
`timescale 1ns/100ps
module tb_fpmac_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic        out_ready;
  logic [3:0]  level;
  logic [31:0] total_cnt;
`ifdef FPMAC_STATS_EN
  logic [15:0] nan_cnt;
  logic [15:0] inf_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int rcv;
  int maxlvl;

  always #5 clk = ~clk;

  fpmac_result_collector #(
    .BIT_WIDTH  (32),
    .EXP_WIDTH  (8),
    .MANT_WIDTH (23),
    .DEPTH      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_ready (out_ready),
    .level     (level),
    .total_cnt (total_cnt)
`ifdef FPMAC_STATS_EN
    ,
    .nan_cnt   (nan_cnt),
    .inf_cnt   (inf_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic pop_one(input string tag, input logic [31:0] w, input logic [3:0] f);
    chk(tag, out_data, w);
    chk(tag, 32'(out_flags), 32'(f));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_total",     total_cnt,      32'd0);

    // Push on the first edge after reset release, then classification set
    rst_n = 1'b1;
    push_one(32'h7FC0_0000);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_level", 32'(level),     32'd1);
    push_one(32'h7F80_0000);
    push_one(32'h8000_0000);
    push_one(32'h0000_0001);
    push_one(32'h3F80_0000);
    chk("cls_level", 32'(level), 32'd5);
    chk("cls_total", total_cnt,  32'd5);
    @(negedge clk);
    pop_one("cls_nan",  32'h7FC0_0000, 4'b1000);
    pop_one("cls_inf",  32'h7F80_0000, 4'b0100);
    pop_one("cls_zero", 32'h8000_0000, 4'b0010);
    pop_one("cls_sub",  32'h0000_0001, 4'b0001);
    pop_one("cls_norm", 32'h3F80_0000, 4'b0000);
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_data",  out_data,       32'd0);

    // Clear wins over a same-cycle push and pop
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h3F80_0000;
    out_ready = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;
    chk("clr_level", 32'(level),     32'd0);
    chk("clr_total", total_cnt,      32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);

    // Fill to full under back-pressure, 9th word refused
    for (int i = 0; i < 8; i++) push_one(32'h3F80_0000 + 32'(i));
    chk("full_level", 32'(level),    32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_total", total_cnt,     32'd8);
    in_valid = 1'b1;
    in_data  = 32'h3F80_00FF;
    @(negedge clk);
    chk("ninth_level", 32'(level), 32'd8);
    chk("ninth_total", total_cnt,  32'd8);
    chk("ninth_head",  out_data,   32'h3F80_0000);
    // Pop while full: push must stay blocked
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;
    chk("fullpop_level", 32'(level),    32'd7);
    chk("fullpop_total", total_cnt,     32'd8);
    chk("fullpop_head",  out_data,      32'h3F80_0001);
    chk("fullpop_ready", 32'(in_ready), 32'd1);

    // Drain to level 3, then one simultaneous push+pop
    for (int i = 1; i < 5; i++) pop_one("drain", 32'h3F80_0000 + 32'(i), 4'b0000);
    chk("l3_level", 32'(level), 32'd3);
    in_valid  = 1'b1;
    in_data   = 32'h4000_0000;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;
    chk("pp_level", 32'(level), 32'd3);
    chk("pp_head",  out_data,   32'h3F80_0006);
    chk("pp_total", total_cnt,  32'd9);
    pop_one("pp_d0", 32'h3F80_0006, 4'b0000);
    pop_one("pp_d1", 32'h3F80_0007, 4'b0000);
    pop_one("pp_d2", 32'h4000_0000, 4'b0000);
    chk("pp_empty", 32'(level), 32'd0);

    // Streaming wrap-around with out_ready held high
    pulse_clear();
    rcv       = 0;
    maxlvl    = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (out_valid) begin
        chk("wrap_order", out_data, 32'h4100_0000 + 32'(rcv));
        rcv++;
      end
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (c < 20) begin
        in_valid = 1'b1;
        in_data  = 32'h4100_0000 + 32'(c);
      end else begin
        in_valid = 1'b0;
        in_data  = 'x;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("wrap_count",  32'(rcv),    32'd20);
    chk("wrap_maxlvl", 32'(maxlvl), 32'd1);
    chk("wrap_total",  total_cnt,   32'd20);
    chk("wrap_level",  32'(level),  32'd0);

    // Asynchronous reset pulse mid-stream
    for (int i = 0; i < 5; i++) push_one(32'h4200_0000 + 32'(i));
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_total", total_cnt,  32'd25);
    #2;
    rst_n = 1'b0;
    #0.1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level),     32'd0);
    chk("arst_total", total_cnt,      32'd0);
    chk("arst_ready", 32'(in_ready),  32'd1);
    chk("arst_data",  out_data,       32'd0);
    #0.2;
    rst_n = 1'b1;
    @(negedge clk);
    push_one(32'h4300_0000);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  out_data,       32'h4300_0000);
    chk("post_rst_level", 32'(level),     32'd1);
    chk("post_rst_total", total_cnt,      32'd1);
    pop_one("post_rst_pop", 32'h4300_0000, 4'b0000);

`ifdef FPMAC_STATS_EN
    // NaN / Inf statistics and their clear
    pulse_clear();
    chk("st_nan0", 32'(nan_cnt), 32'd0);
    chk("st_inf0", 32'(inf_cnt), 32'd0);
    push_one(32'h7FC0_0001);
    push_one(32'hFFFF_FFFF);
    push_one(32'h7F80_0001);
    push_one(32'h7F80_0000);
    push_one(32'hFF80_0000);
    push_one(32'h3F80_0000);
    chk("st_nan", 32'(nan_cnt), 32'd3);
    chk("st_inf", 32'(inf_cnt), 32'd2);
    pulse_clear();
    chk("st_nan_clr", 32'(nan_cnt), 32'd0);
    chk("st_inf_clr", 32'(inf_cnt), 32'd0);
    chk("st_lvl_clr", 32'(level),   32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
